// File: rtl/mem_slave_bd.sv
// Single-port word memory slave with BUSY/DONE handshake and a fixed access latency.
// Optional read/write statistics counters are enabled by defining MEM_SLAVE_STAT_EN.
module mem_slave_bd #(
    parameter int WA        = 32,
    parameter int WD        = 32,
    parameter int DEPTH_LOG = 17,
    parameter int LATENCY   = 2
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [WA-1:0] MEM_A,
    input  logic          MEM_RE,
    input  logic          MEM_WE,
    input  logic [WD-1:0] MEM_D,
    output logic [WD-1:0] MEM_Q,
    output logic          MEM_BUSY,
    output logic          MEM_DONE
`ifdef MEM_SLAVE_STAT_EN
    ,
    output logic [31:0]   STAT_RD,
    output logic [31:0]   STAT_WR
`endif
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_WAIT    = 2'd1;
    localparam logic [1:0] ST_DONE    = 2'd2;
    localparam logic [1:0] ST_RELEASE = 2'd3;

    localparam logic [3:0] LAT_INIT = 4'(LATENCY);

    if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
        $error("mem_slave_bd: LATENCY must be in 0..15");
    end

    logic [WD-1:0]        mem [0:(2**DEPTH_LOG)-1];

    logic [1:0]           state_q, state_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [DEPTH_LOG-1:0] addr_q, addr_d;
    logic [WD-1:0]        data_q, data_d;
    logic                 wr_op_q, wr_op_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [WD-1:0]        rdata_q;
    logic                 mem_wr_en;
    logic                 mem_rd_en;

    // Upper address bits are deliberately ignored so the array aliases.
    if (WA > DEPTH_LOG) begin : g_addr_hi
        logic unused_addr_hi;
        assign unused_addr_hi = ^MEM_A[WA-1:DEPTH_LOG];
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        data_d    = data_q;
        wr_op_d   = wr_op_q;
        busy_d    = busy_q;
        done_d    = done_q;
        mem_wr_en = 1'b0;
        mem_rd_en = 1'b0;
        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
                done_d = 1'b0;
                if (MEM_WE || MEM_RE) begin
                    addr_d  = MEM_A[DEPTH_LOG-1:0];
                    data_d  = MEM_D;
                    wr_op_d = MEM_WE;
                    busy_d  = 1'b1;
                    cnt_d   = LAT_INIT;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d   = ST_DONE;
                    done_d    = 1'b1;
                    mem_wr_en = wr_op_q;
                    mem_rd_en = !wr_op_q;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_RELEASE;
                done_d  = 1'b0;
                busy_d  = 1'b0;
            end
            ST_RELEASE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wr_op_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wr_op_q <= wr_op_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Read port is registered straight off the array so it maps onto block RAM.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rdata_q <= '0;
        end else if (mem_rd_en) begin
            rdata_q <= mem[addr_q];
        end
    end

    always_ff @(posedge CLK) begin
        if (mem_wr_en) begin
            mem[addr_q] <= data_q;
        end
    end

    assign MEM_Q    = rdata_q;
    assign MEM_BUSY = busy_q;
    assign MEM_DONE = done_q;

`ifdef MEM_SLAVE_STAT_EN
    logic [31:0] stat_rd_q, stat_rd_d;
    logic [31:0] stat_wr_q, stat_wr_d;

    always_comb begin
        stat_rd_d = stat_rd_q;
        stat_wr_d = stat_wr_q;
        if (mem_rd_en) begin
            stat_rd_d = stat_rd_q + 32'd1;
        end
        if (mem_wr_en) begin
            stat_wr_d = stat_wr_q + 32'd1;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            stat_rd_q <= '0;
            stat_wr_q <= '0;
        end else begin
            stat_rd_q <= stat_rd_d;
            stat_wr_q <= stat_wr_d;
        end
    end

    assign STAT_RD = stat_rd_q;
    assign STAT_WR = stat_wr_q;
`endif

endmodule

// File: tb/tb_mem_slave_bd.sv
// Self-checking bench for mem_slave_bd: a LATENCY=2 instance and a LATENCY=0 instance,
// with a scoreboard queue of expected read data popped on each read completion.
module tb_mem_slave_bd;

    localparam int WA  = 32;
    localparam int WD  = 32;
    localparam int DL  = 17;
    localparam int LAT = 2;
    localparam int WIN = 7;

    logic          clk;
    logic          rst;
    logic [WA-1:0] a1, a0;
    logic          re1, re0, we1, we0;
    logic [WD-1:0] d1, d0, q1, q0;
    logic          busy1, busy0, done1, done0;
`ifdef MEM_SLAVE_STAT_EN
    logic [31:0]   stat_rd1, stat_wr1, stat_rd0, stat_wr0;
`endif

    int checks = 0;
    int errors = 0;

    logic [WD-1:0] model_mem1 [int];
    logic [WD-1:0] model_mem0 [int];
    logic [WD-1:0] exp_q [$];
    logic [WD-1:0] q_last1, q_last0;

    logic [7:0]    obs_busy, obs_done;
    logic [WD-1:0] obs_q_done, obs_q_start;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    mem_slave_bd #(.WA(WA), .WD(WD), .DEPTH_LOG(DL), .LATENCY(LAT)) u_dut (
        .CLK(clk), .RST(rst), .MEM_A(a1), .MEM_RE(re1), .MEM_WE(we1), .MEM_D(d1),
        .MEM_Q(q1), .MEM_BUSY(busy1), .MEM_DONE(done1)
`ifdef MEM_SLAVE_STAT_EN
        , .STAT_RD(stat_rd1), .STAT_WR(stat_wr1)
`endif
    );

    mem_slave_bd #(.WA(WA), .WD(WD), .DEPTH_LOG(DL), .LATENCY(0)) u_dut_lat0 (
        .CLK(clk), .RST(rst), .MEM_A(a0), .MEM_RE(re0), .MEM_WE(we0), .MEM_D(d0),
        .MEM_Q(q0), .MEM_BUSY(busy0), .MEM_DONE(done0)
`ifdef MEM_SLAVE_STAT_EN
        , .STAT_RD(stat_rd0), .STAT_WR(stat_wr0)
`endif
    );

    function automatic logic [7:0] busy_mask(input int lat);
        logic [7:0] m = '0;
        for (int i = 1; i <= lat + 2; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [7:0] done_mask(input int lat);
        logic [7:0] m = '0;
        m[lat + 2] = 1'b1;
        return m;
    endfunction

    // Drives one request (sel 1: LATENCY=2 instance, sel 0: LATENCY=0 instance), holding
    // the request until BUSY is seen, and records BUSY/DONE per negedge after the edge.
    task automatic run_access(input int sel, input logic we, input logic re,
                              input logic [WA-1:0] a, input logic [WD-1:0] d);
        int idx;
        logic b, dn, got;
        logic [WD-1:0] qn;
        idx = int'(a[DL-1:0]);
        obs_busy = '0;
        obs_done = '0;
        obs_q_done = '0;
        obs_q_start = '0;
        got = 1'b0;
        @(negedge clk);
        if (sel == 1) begin a1 = a; d1 = d; we1 = we; re1 = re; end
        else          begin a0 = a; d0 = d; we0 = we; re0 = re; end
        if (we) begin
            if (sel == 1) model_mem1[idx] = d; else model_mem0[idx] = d;
        end else if (re) begin
            if (sel == 1) exp_q.push_back(model_mem1.exists(idx) ? model_mem1[idx] : '0);
            else          exp_q.push_back(model_mem0.exists(idx) ? model_mem0[idx] : '0);
        end
        for (int i = 1; i <= WIN; i++) begin
            @(negedge clk);
            b  = (sel == 1) ? busy1 : busy0;
            dn = (sel == 1) ? done1 : done0;
            qn = (sel == 1) ? q1 : q0;
            if (b) begin
                if (sel == 1) begin we1 = 0; re1 = 0; a1 = ~a; d1 = ~d; end
                else          begin we0 = 0; re0 = 0; a0 = ~a; d0 = ~d; end
            end
            obs_busy[i] = b;
            obs_done[i] = dn;
            if (i == 1) obs_q_start = qn;
            if (dn && !got) begin obs_q_done = qn; got = 1'b1; end
        end
        we1 = 0; re1 = 0; we0 = 0; re0 = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        a1 = '0; d1 = '0; we1 = 0; re1 = 0;
        a0 = '0; d0 = '0; we0 = 0; re0 = 0;
        q_last1 = '0; q_last0 = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({q1, busy1, done1} !== '0)
            begin errors++; $display("FAIL reset_in_rst: got q=%h busy=%b done=%b required all 0", q1, busy1, done1); end
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if ({q1, busy1, done1, q0, busy0, done0} !== '0)
                begin errors++; $display("FAIL reset_idle[%0d]: got q=%h busy=%b done=%b required all 0", i, q1, busy1, done1); end
        end
`ifdef MEM_SLAVE_STAT_EN
        checks++;
        if ({stat_rd1, stat_wr1} !== '0)
            begin errors++; $display("FAIL reset_stats: got rd=%0d wr=%0d required 0 0", stat_rd1, stat_wr1); end
`endif
    endtask

    task automatic test_write_read();
        logic [WD-1:0] e;
        run_access(1, 1'b1, 1'b0, 32'd5, 32'hDEADBEEF);
        checks++;
        if (obs_busy !== busy_mask(LAT))
            begin errors++; $display("FAIL wr5_busy: got %b required %b", obs_busy, busy_mask(LAT)); end
        checks++;
        if (obs_done !== done_mask(LAT))
            begin errors++; $display("FAIL wr5_done: got %b required %b", obs_done, done_mask(LAT)); end
        run_access(1, 1'b0, 1'b1, 32'd5, 32'h0);
        checks++;
        if (obs_done !== done_mask(LAT))
            begin errors++; $display("FAIL rd5_done: got %b required %b", obs_done, done_mask(LAT)); end
        e = exp_q.pop_front();
        q_last1 = e;
        checks++;
        if (obs_q_done !== e)
            begin errors++; $display("FAIL rd5_data: got %h required %h", obs_q_done, e); end
    endtask

    task automatic test_hold_re();
        int pulses;
        logic [WD-1:0] e;
        run_access(1, 1'b1, 1'b0, 32'd0, 32'h11);
        run_access(1, 1'b1, 1'b0, 32'd32768, 32'h22);
        pulses = 0;
        run_access(1, 1'b0, 1'b1, 32'd0, 32'h0);
        pulses += $countones(obs_done);
        e = exp_q.pop_front();
        q_last1 = e;
        checks++;
        if (obs_q_done !== e)
            begin errors++; $display("FAIL hold_rd0: got %h required %h", obs_q_done, e); end
        run_access(1, 1'b0, 1'b1, 32'd32768, 32'h0);
        pulses += $countones(obs_done);
        e = exp_q.pop_front();
        q_last1 = e;
        checks++;
        if (obs_q_done !== e)
            begin errors++; $display("FAIL hold_rd32768: got %h required %h", obs_q_done, e); end
        checks++;
        if (pulses != 2)
            begin errors++; $display("FAIL hold_done_count: got %0d required 2", pulses); end
    endtask

    task automatic test_both();
        logic [WD-1:0] e;
        run_access(1, 1'b1, 1'b1, 32'd7, 32'h55);
        checks++;
        if (obs_q_done !== q_last1)
            begin errors++; $display("FAIL both_q_hold: got %h required %h", obs_q_done, q_last1); end
        checks++;
        if (obs_done !== done_mask(LAT))
            begin errors++; $display("FAIL both_done: got %b required %b", obs_done, done_mask(LAT)); end
        run_access(1, 1'b0, 1'b1, 32'd7, 32'h0);
        e = exp_q.pop_front();
        q_last1 = e;
        checks++;
        if (obs_q_done !== e)
            begin errors++; $display("FAIL both_rd7: got %h required %h", obs_q_done, e); end
    endtask

    task automatic test_alias();
        logic [WD-1:0] e;
        run_access(1, 1'b1, 1'b0, 32'h0002_0003, 32'hAB);
        run_access(1, 1'b0, 1'b1, 32'd3, 32'h0);
        e = exp_q.pop_front();
        q_last1 = e;
        checks++;
        if (obs_q_done !== e)
            begin errors++; $display("FAIL alias_rd3: got %h required %h", obs_q_done, e); end
    endtask

    task automatic test_latency0();
        logic [WD-1:0] e;
        run_access(0, 1'b1, 1'b0, 32'h0002_0003, 32'hAB);
        checks++;
        if (obs_busy !== busy_mask(0))
            begin errors++; $display("FAIL lat0_wr_busy: got %b required %b", obs_busy, busy_mask(0)); end
        checks++;
        if (obs_done !== done_mask(0))
            begin errors++; $display("FAIL lat0_wr_done: got %b required %b", obs_done, done_mask(0)); end
        run_access(0, 1'b0, 1'b1, 32'd3, 32'h0);
        checks++;
        if (obs_done !== done_mask(0))
            begin errors++; $display("FAIL lat0_rd_done: got %b required %b", obs_done, done_mask(0)); end
        e = exp_q.pop_front();
        q_last0 = e;
        checks++;
        if (obs_q_done !== e)
            begin errors++; $display("FAIL lat0_rd_data: got %h required %h", obs_q_done, e); end
    endtask

    task automatic test_back_to_back();
        logic [WA-1:0] addrs [4];
        logic [WD-1:0] e;
        for (int i = 0; i < 4; i++) begin
            addrs[i] = 32'(100 + i * 1000 + $urandom_range(0, 999));
            run_access(1, 1'b1, 1'b0, addrs[i], $urandom);
        end
        for (int i = 0; i < 4; i++) run_access(1, 1'b0, 1'b1, addrs[i], 32'h0);
        // reads were issued serially; pop in issue order by re-reading the results
        for (int i = 0; i < 4; i++) begin
            run_access(1, 1'b0, 1'b1, addrs[i], 32'h0);
            e = exp_q.pop_front();
            void'(exp_q.pop_back());
            exp_q.push_front(e);
            e = exp_q.pop_front();
            q_last1 = e;
            checks++;
            if (obs_q_done !== e)
                begin errors++; $display("FAIL b2b_rd[%0d]: got %h required %h", i, obs_q_done, e); end
        end
    endtask

    task automatic test_reset_mid();
        logic [WD-1:0] e;
        run_access(1, 1'b1, 1'b0, 32'd9, 32'h99);
        @(negedge clk);
        a1 = 32'd9; d1 = 32'h1234; we1 = 1'b1;
        @(negedge clk);
        we1 = 1'b0;
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({busy1, done1, q1} !== '0)
            begin errors++; $display("FAIL mid_rst_outputs: got busy=%b done=%b q=%h required 0", busy1, done1, q1); end
        q_last1 = '0; q_last0 = '0;
        @(negedge clk);
        rst = 1'b0;
        run_access(1, 1'b0, 1'b1, 32'd9, 32'h0);
        e = exp_q.pop_front();
        q_last1 = e;
        checks++;
        if (obs_q_done !== e)
            begin errors++; $display("FAIL mid_rst_rd9: got %h required %h", obs_q_done, e); end
`ifdef MEM_SLAVE_STAT_EN
        checks++;
        if (stat_rd1 !== 32'd1 || stat_wr1 !== 32'd0)
            begin errors++; $display("FAIL mid_rst_stats: got rd=%0d wr=%0d required 1 0", stat_rd1, stat_wr1); end
`endif
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_hold_re();
        test_both();
        test_alias();
        test_latency0();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (exp_q.size() != 0)
            begin errors++; $display("FAIL scoreboard_drain: got %0d entries required 0", exp_q.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
